// File: rtl/irq_context_stack.sv
// irq_context_stack: interrupt entry/return context unit.
// Saves {PC, GT, EQ} on interrupt entry and restores them on Iret, redirecting
// fetch to handler_pc (entry) or ret_pc (return).
// Optional build macro IRQ_NESTING_EN: when defined, handlers nest up to DEPTH
// levels; when undefined, only one context is held and irqs are taken from IDLE only.
module irq_context_stack #(
    parameter int              DEPTH  = 4,
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] VECTOR = PC_W'(32'h0000_0100)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         irq_req,
    input  logic                         int_en,
    input  logic                         stall,
    input  logic                         iret,
    input  logic [PC_W-1:0]              pc_in,
    input  logic                         gt_in,
    input  logic                         eq_in,
    output logic                         take_irq,
    output logic [PC_W-1:0]              handler_pc,
    output logic                         irq_ack,
    output logic                         ret_valid,
    output logic [PC_W-1:0]              ret_pc,
    output logic [1:0]                   flag_D_out,
    output logic                         in_service,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err_underflow
);

    localparam int DW = $clog2(DEPTH+1);
`ifdef IRQ_NESTING_EN
    localparam int DEPTH_EFF = DEPTH;
`else
    localparam int DEPTH_EFF = 1;
`endif
    localparam int AW = (DEPTH_EFF > 1) ? $clog2(DEPTH_EFF) : 1;
    localparam logic [DW-1:0] DEPTH_EFF_W = DW'(DEPTH_EFF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     depth_reg;
    logic [DW-1:0]     depth_dec;
    logic [PC_W-1:0]   ret_pc_reg;
    logic [1:0]        flag_reg;
    logic              err_reg;
    logic              do_push, do_pop, set_uf;
    logic [AW-1:0]     push_idx, pop_idx;

    // Saved contexts, packed as {pc, gt, eq}; never reset, only read via a register.
    logic [PC_W+1:0]   stack_mem [DEPTH_EFF];

    assign depth_dec = depth_reg - DW'(1);

    // Top-of-stack addressing; a single-entry stack always uses slot 0.
    generate
        if (DEPTH_EFF > 1) begin : g_nest_idx
            assign push_idx = depth_reg[AW-1:0];
            assign pop_idx  = depth_dec[AW-1:0];
        end else begin : g_single_idx
            assign push_idx = '0;
            assign pop_idx  = '0;
        end
    endgenerate

    // State register; reset drops any in-flight ENTER/RETURN pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, push/pop decisions and pulse outputs; Iret has priority over an irq.
    always_comb begin
        state_next = state_reg;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_uf     = 1'b0;
        take_irq   = 1'b0;
        irq_ack    = 1'b0;
        ret_valid  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ACTIVE: begin
                if (!stall) begin
                    if (iret) begin
                        if (depth_reg != '0) begin
                            do_pop     = 1'b1;
                            state_next = ST_RETURN;
                        end else begin
                            set_uf = 1'b1;
                        end
                    end else if (irq_req && int_en && (depth_reg < DEPTH_EFF_W)) begin
                        do_push    = 1'b1;
                        state_next = ST_ENTER;
                    end
                end
            end
            ST_ENTER: begin
                take_irq   = 1'b1;
                irq_ack    = 1'b1;
                state_next = ST_ACTIVE;
            end
            ST_RETURN: begin
                ret_valid  = 1'b1;
                state_next = (depth_reg != '0) ? ST_ACTIVE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Context write on entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= {pc_in, gt_in, eq_in};
        end
    end

    // Depth counter, registered restore of PC/flags, sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_reg  <= '0;
            ret_pc_reg <= '0;
            flag_reg   <= 2'b00;
            err_reg    <= 1'b0;
        end else begin
            if (do_push) begin
                depth_reg <= depth_reg + DW'(1);
            end else if (do_pop) begin
                depth_reg <= depth_dec;
                {ret_pc_reg, flag_reg} <= stack_mem[pop_idx];
            end
            if (set_uf) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign handler_pc    = VECTOR;
    assign ret_pc        = ret_pc_reg;
    assign flag_D_out    = flag_reg;
    assign depth         = depth_reg;
    assign in_service    = (depth_reg != '0);
    assign err_underflow = err_reg;

endmodule

// File: tb/tb_irq_context_stack.sv
// Directed bench for irq_context_stack (default parameters DEPTH=4, VECTOR=0x100).
// Expectations for the nesting sequence follow IRQ_NESTING_EN.
module tb_irq_context_stack;

    logic        clk = 1'b0;
    logic        rst_n, irq_req, int_en, stall, iret, gt_in, eq_in;
    logic [31:0] pc_in;
    logic        take_irq, irq_ack, ret_valid, in_service, err_underflow;
    logic [31:0] handler_pc, ret_pc;
    logic [1:0]  flag_D_out;
    logic [2:0]  depth;

    int checks = 0;
    int errors = 0;
    string tag;

    always #5 clk = ~clk;

    irq_context_stack dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .int_en(int_en),
        .stall(stall), .iret(iret), .pc_in(pc_in), .gt_in(gt_in), .eq_in(eq_in),
        .take_irq(take_irq), .handler_pc(handler_pc), .irq_ack(irq_ack),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .flag_D_out(flag_D_out),
        .in_service(in_service), .depth(depth), .err_underflow(err_underflow)
    );

    typedef struct {
        logic        rst_n;
        logic        irq;
        logic        en;
        logic        stall;
        logic        iret;
        logic [31:0] pc;
        logic        gt;
        logic        eq;
        logic        e_take;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [1:0]  e_fl;
        logic [2:0]  e_dep;
        logic        e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic run_vec(input string name, input vec_t v);
        rst_n = v.rst_n; irq_req = v.irq; int_en = v.en; stall = v.stall;
        iret = v.iret; pc_in = v.pc; gt_in = v.gt; eq_in = v.eq;
        @(posedge clk);
        #1;
        tag = name;
        chk("take_irq",      32'(take_irq),      32'(v.e_take));
        chk("irq_ack",       32'(irq_ack),       32'(v.e_take));
        chk("ret_valid",     32'(ret_valid),     32'(v.e_rv));
        chk("ret_pc",        ret_pc,             v.e_rpc);
        chk("flag_D_out",    32'(flag_D_out),    32'(v.e_fl));
        chk("depth",         32'(depth),         32'(v.e_dep));
        chk("in_service",    32'(in_service),    32'(v.e_dep != 3'd0));
        chk("err_underflow", 32'(err_underflow), 32'(v.e_err));
        chk("handler_pc",    handler_pc,         32'h0000_0100);
        $display("vec %s: rst_n=%0b irq=%0b en=%0b stall=%0b iret=%0b -> take=%0b rv=%0b ret_pc=%0h fl=%0b depth=%0d err=%0b",
                 name, v.rst_n, v.irq, v.en, v.stall, v.iret, take_irq, ret_valid, ret_pc, flag_D_out, depth, err_underflow);
    endtask

    vec_t tbl [22];
    vec_t seq_a [4];
`ifdef IRQ_NESTING_EN
    vec_t seq_b [22];
`else
    vec_t seq_b [10];
`endif

    initial begin
        rst_n = 1'b0; irq_req = 1'b0; int_en = 1'b0; stall = 1'b0;
        iret = 1'b0; pc_in = '0; gt_in = 1'b0; eq_in = 1'b0;

        //          rst irq en st iret pc            gt eq | take rv rpc            fl     dep   err
        tbl[0]  = '{0, 0, 0, 0, 0, 32'h0,   0, 0,   0, 0, 32'h0,   2'b00, 3'd0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,   0, 0,   0, 0, 32'h0,   2'b00, 3'd0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 32'h40,  1, 0,   1, 0, 32'h0,   2'b00, 3'd1, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 32'h44,  0, 0,   0, 0, 32'h0,   2'b00, 3'd1, 0};
        tbl[4]  = '{1, 0, 1, 0, 1, 32'h44,  0, 0,   0, 1, 32'h40,  2'b10, 3'd0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 32'h44,  0, 0,   0, 0, 32'h40,  2'b10, 3'd0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 32'h200, 0, 1,   0, 0, 32'h40,  2'b10, 3'd0, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 32'h200, 0, 1,   0, 0, 32'h40,  2'b10, 3'd0, 0};
        tbl[8]  = '{1, 1, 1, 0, 0, 32'h200, 0, 1,   1, 0, 32'h40,  2'b10, 3'd1, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 32'h204, 0, 0,   0, 0, 32'h40,  2'b10, 3'd1, 0};
        tbl[10] = '{1, 1, 1, 1, 1, 32'h204, 0, 0,   0, 0, 32'h40,  2'b10, 3'd1, 0};
        tbl[11] = '{1, 1, 1, 1, 1, 32'h204, 0, 0,   0, 0, 32'h40,  2'b10, 3'd1, 0};
        tbl[12] = '{1, 1, 1, 1, 1, 32'h204, 0, 0,   0, 0, 32'h40,  2'b10, 3'd1, 0};
        tbl[13] = '{1, 1, 1, 0, 1, 32'h204, 0, 0,   0, 1, 32'h200, 2'b01, 3'd0, 0};
        tbl[14] = '{1, 1, 1, 0, 0, 32'h300, 1, 1,   0, 0, 32'h200, 2'b01, 3'd0, 0};
        tbl[15] = '{1, 1, 1, 0, 0, 32'h300, 1, 1,   1, 0, 32'h200, 2'b01, 3'd1, 0};
        tbl[16] = '{1, 0, 1, 0, 0, 32'h304, 0, 0,   0, 0, 32'h200, 2'b01, 3'd1, 0};
        tbl[17] = '{1, 0, 1, 0, 1, 32'h304, 0, 0,   0, 1, 32'h300, 2'b11, 3'd0, 0};
        tbl[18] = '{1, 0, 1, 0, 0, 32'h304, 0, 0,   0, 0, 32'h300, 2'b11, 3'd0, 0};
        tbl[19] = '{1, 0, 1, 0, 1, 32'h304, 0, 0,   0, 0, 32'h300, 2'b11, 3'd0, 1};
        tbl[20] = '{1, 0, 1, 0, 0, 32'h304, 0, 0,   0, 0, 32'h300, 2'b11, 3'd0, 1};
        tbl[21] = '{1, 0, 1, 0, 1, 32'h304, 0, 0,   0, 0, 32'h300, 2'b11, 3'd0, 1};

        // Reset landing in the ENTER cycle, then an Iret on the emptied stack.
        seq_a[0] = '{0, 0, 1, 0, 0, 32'h0,   0, 0,   0, 0, 32'h0,   2'b00, 3'd0, 0};
        seq_a[1] = '{1, 1, 1, 0, 0, 32'h80,  1, 1,   1, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_a[2] = '{0, 0, 1, 0, 0, 32'h84,  0, 0,   0, 0, 32'h0,   2'b00, 3'd0, 0};
        seq_a[3] = '{1, 0, 1, 0, 1, 32'h84,  0, 0,   0, 0, 32'h0,   2'b00, 3'd0, 1};

`ifdef IRQ_NESTING_EN
        // Three nested entries, a fourth fills the stack, held irq waits, LIFO unwind.
        seq_b[0]  = '{0, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   2'b00, 3'd0, 0};
        seq_b[1]  = '{1, 1, 1, 0, 0, 32'h40,  0, 1,  1, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[2]  = '{1, 0, 1, 0, 0, 32'h44,  0, 0,  0, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[3]  = '{1, 1, 1, 0, 0, 32'h104, 1, 0,  1, 0, 32'h0,   2'b00, 3'd2, 0};
        seq_b[4]  = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   2'b00, 3'd2, 0};
        seq_b[5]  = '{1, 1, 1, 0, 0, 32'h108, 1, 1,  1, 0, 32'h0,   2'b00, 3'd3, 0};
        seq_b[6]  = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   2'b00, 3'd3, 0};
        seq_b[7]  = '{1, 1, 1, 0, 0, 32'h10C, 0, 0,  1, 0, 32'h0,   2'b00, 3'd4, 0};
        seq_b[8]  = '{1, 1, 1, 0, 0, 32'h500, 0, 0,  0, 0, 32'h0,   2'b00, 3'd4, 0};
        seq_b[9]  = '{1, 1, 1, 0, 0, 32'h500, 0, 0,  0, 0, 32'h0,   2'b00, 3'd4, 0};
        seq_b[10] = '{1, 1, 1, 0, 1, 32'h500, 0, 0,  0, 1, 32'h10C, 2'b00, 3'd3, 0};
        seq_b[11] = '{1, 1, 1, 0, 0, 32'h500, 0, 0,  0, 0, 32'h10C, 2'b00, 3'd3, 0};
        seq_b[12] = '{1, 1, 1, 0, 0, 32'h500, 0, 0,  1, 0, 32'h10C, 2'b00, 3'd4, 0};
        seq_b[13] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h10C, 2'b00, 3'd4, 0};
        seq_b[14] = '{1, 0, 1, 0, 1, 32'h0,   0, 0,  0, 1, 32'h500, 2'b00, 3'd3, 0};
        seq_b[15] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h500, 2'b00, 3'd3, 0};
        seq_b[16] = '{1, 0, 1, 0, 1, 32'h0,   0, 0,  0, 1, 32'h108, 2'b11, 3'd2, 0};
        seq_b[17] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h108, 2'b11, 3'd2, 0};
        seq_b[18] = '{1, 0, 1, 0, 1, 32'h0,   0, 0,  0, 1, 32'h104, 2'b10, 3'd1, 0};
        seq_b[19] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h104, 2'b10, 3'd1, 0};
        seq_b[20] = '{1, 0, 1, 0, 1, 32'h0,   0, 0,  0, 1, 32'h40,  2'b01, 3'd0, 0};
        seq_b[21] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h40,  2'b01, 3'd0, 0};
`else
        // Without nesting a second irq stays pending until the stack empties.
        seq_b[0] = '{0, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   2'b00, 3'd0, 0};
        seq_b[1] = '{1, 1, 1, 0, 0, 32'h40,  0, 1,  1, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[2] = '{1, 0, 1, 0, 0, 32'h44,  0, 0,  0, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[3] = '{1, 1, 1, 0, 0, 32'h104, 1, 0,  0, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[4] = '{1, 1, 1, 0, 0, 32'h104, 1, 0,  0, 0, 32'h0,   2'b00, 3'd1, 0};
        seq_b[5] = '{1, 0, 1, 0, 1, 32'h104, 1, 0,  0, 1, 32'h40,  2'b01, 3'd0, 0};
        seq_b[6] = '{1, 0, 1, 0, 0, 32'h104, 1, 0,  0, 0, 32'h40,  2'b01, 3'd0, 0};
        seq_b[7] = '{1, 1, 1, 0, 0, 32'h104, 1, 0,  1, 0, 32'h40,  2'b01, 3'd1, 0};
        seq_b[8] = '{1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h40,  2'b01, 3'd1, 0};
        seq_b[9] = '{1, 0, 1, 0, 1, 32'h0,   0, 0,  0, 1, 32'h104, 2'b10, 3'd0, 0};
`endif

        for (int i = 0; i < $size(tbl); i++)   run_vec($sformatf("tbl%0d", i), tbl[i]);
        for (int i = 0; i < $size(seq_a); i++) run_vec($sformatf("rst_mid%0d", i), seq_a[i]);
        for (int i = 0; i < $size(seq_b); i++) run_vec($sformatf("nest%0d", i), seq_b[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
